// File: rtl/sqrt_req_sched.sv
// rtl/sqrt_req_sched.sv - request scheduler feeding the iterative sqrt unit
// Buffers operands in a FIFO, issues them one at a time, returns results with a watchdog.
module sqrt_req_sched #(
    parameter int NBITS   = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [NBITS-1:0]           in_data_i,
    output logic                       sq_start_o,
    output logic [NBITS-1:0]           sq_n_o,
    input  logic                       sq_busy_i,
    input  logic                       sq_valid_i,
    input  logic [NBITS-1:0]           sq_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NBITS-1:0]           out_op_o,
    output logic [NBITS-1:0]           out_result_o,
    output logic                       out_err_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [NBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WW-1:0]    wd_cnt;
    logic             push;
    logic             pop;
    logic             timed_out;

    assign level_o    = level;
    assign in_ready_o = (level != LW'(DEPTH));
    assign push       = in_valid_i && in_ready_o;
    // A pop is exactly the IDLE->ISSUE transition; the held result must drain first.
    assign pop        = (state == S_IDLE) && (level != '0) && !sq_busy_i && !out_valid_o;
    assign sq_start_o = (state == S_ISSUE);
    assign timed_out  = (wd_cnt == WW'(TIMEOUT-1));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (pop) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (sq_valid_i || timed_out) state_nx = S_HOLD;
            S_HOLD:  if (out_ready_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            wd_cnt       <= '0;
            sq_n_o       <= '0;
            out_valid_o  <= 1'b0;
            out_op_o     <= '0;
            out_result_o <= '0;
            out_err_o    <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sq_n_o <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
            unique case (state)
                S_ISSUE: wd_cnt <= '0;
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // A real completion wins over a same-cycle timeout.
                    if (sq_valid_i) begin
                        out_valid_o  <= 1'b1;
                        out_op_o     <= sq_n_o;
                        out_result_o <= sq_result_i;
                        out_err_o    <= 1'b0;
                    end else if (timed_out) begin
                        out_valid_o  <= 1'b1;
                        out_op_o     <= sq_n_o;
                        out_result_o <= '0;
                        out_err_o    <= 1'b1;
                    end
                end
                S_HOLD: if (out_ready_i) out_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_req_sched.sv
// tb/tb_sqrt_req_sched.sv - scoreboard bench for sqrt_req_sched with a behavioural sqrt stub
module tb_sqrt_req_sched;

    localparam int NBITS   = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH+1);

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b1;
    logic             in_valid_i  = 1'b0;
    logic [NBITS-1:0] in_data_i   = '0;
    logic             out_ready_i = 1'b1;
    logic [NBITS-1:0] sq_result_i = '0;
    logic             in_ready_o;
    logic             sq_start_o;
    logic [NBITS-1:0] sq_n_o;
    logic             sq_busy_i;
    logic             sq_valid_i;
    logic             out_valid_o;
    logic [NBITS-1:0] out_op_o;
    logic [NBITS-1:0] out_result_o;
    logic             out_err_o;
    logic [LW-1:0]    level_o;

    logic stub_busy    = 1'b0;
    logic stub_valid   = 1'b0;
    logic force_busy   = 1'b0;
    logic man_valid    = 1'b0;
    logic stub_respond = 1'b1;
    int   stub_lat     = 3;
    int   stub_cnt     = 0;
    logic stub_active  = 1'b0;
    logic [NBITS-1:0] stub_op = '0;

    assign sq_busy_i  = stub_busy | force_busy;
    assign sq_valid_i = stub_valid | man_valid;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_starts = 0;
    int peak     = 0;

    typedef struct {
        logic [NBITS-1:0] op;
        logic [NBITS-1:0] res;
        logic             err;
    } exp_t;
    exp_t sb[$];

    sqrt_req_sched #(.NBITS(NBITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .sq_start_o(sq_start_o), .sq_n_o(sq_n_o), .sq_busy_i(sq_busy_i),
        .sq_valid_i(sq_valid_i), .sq_result_i(sq_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_op_o(out_op_o),
        .out_result_o(out_result_o), .out_err_o(out_err_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Monitor: compares every accepted output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sq_start_o) n_starts++;
            if (int'(level_o) > peak) peak = int'(level_o);
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'(out_op_o), -1);
                end else begin
                    e = sb.pop_front();
                    check("out_op", int'(out_op_o), int'(e.op));
                    check("out_result", int'(out_result_o), int'(e.res));
                    check("out_err", int'(out_err_o), int'(e.err));
                end
            end
        end
    end

    // sqrt stub: latches N on start, busy for stub_lat+1 cycles, then pulses valid.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            stub_valid = 1'b0;
            if (rst_i) begin
                stub_active = 1'b0;
            end else if (stub_active) begin
                if (stub_cnt == 0) begin
                    stub_active = 1'b0;
                    if (stub_respond) begin
                        stub_valid  = 1'b1;
                        sq_result_i = NBITS'(isqrt(int'(stub_op)));
                    end
                end else begin
                    stub_cnt--;
                end
            end else if (sq_start_o) begin
                stub_active = 1'b1;
                stub_cnt    = stub_lat;
                stub_op     = sq_n_o;
            end
            stub_busy = stub_active;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push(input int d, input int r, input int e, input bit track = 1'b1);
        int t = 0;
        exp_t x;
        in_valid_i = 1'b1;
        in_data_i  = NBITS'(d);
        while (!in_ready_o && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready_o) begin
            check("push_accept", 0, 1);
            in_valid_i = 1'b0;
        end else begin
            if (track) begin
                x.op  = NBITS'(d);
                x.res = NBITS'(r);
                x.err = e[0];
                sb.push_back(x);
            end
            tick();
            in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        check("drain", sb.size(), 0);
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready_o), 1);
        check({tag, "_level"}, int'(level_o), 0);
        check({tag, "_start"}, int'(sq_start_o), 0);
        check({tag, "_sq_n"}, int'(sq_n_o), 0);
        check({tag, "_out_valid"}, int'(out_valid_o), 0);
        check({tag, "_out_op"}, int'(out_op_o), 0);
        check({tag, "_out_result"}, int'(out_result_o), 0);
        check({tag, "_out_err"}, int'(out_err_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        int t;
        bit stable;
        bit seen;

        tick(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Single request with issue-latency checks
        s0 = n_starts;
        push(16, 4, 0);
        check("single_level", int'(level_o), 1);
        check("single_no_start_yet", int'(sq_start_o), 0);
        tick();
        check("single_start", int'(sq_start_o), 1);
        check("single_sq_n", int'(sq_n_o), 16);
        check("single_level_popped", int'(level_o), 0);
        tick();
        check("single_start_one_cycle", int'(sq_start_o), 0);
        wait_drain(100);
        check("single_starts", n_starts - s0, 1);

        // Ordered queue
        s0 = n_starts;
        push(16, 4, 0);
        push(6, 2, 0);
        push(25, 5, 0);
        push(9, 3, 0);
        wait_drain(200);
        check("ordered_peak_ge3", int'(peak >= 3), 1);
        check("ordered_starts", n_starts - s0, 4);

        // Backpressure with sqrt held busy
        s0 = n_starts;
        force_busy = 1'b1;
        push(1, 1, 0);
        push(4, 2, 0);
        push(8, 2, 0);
        push(15, 3, 0);
        check("bp_ready_low", int'(in_ready_o), 0);
        check("bp_level_full", int'(level_o), 4);
        in_valid_i = 1'b1;
        in_data_i  = 5'd24;
        tick(3);
        check("bp_level_held", int'(level_o), 4);
        check("bp_no_start", n_starts - s0, 0);
        force_busy = 1'b0;
        tick();
        check("bp_pop_no_push", int'(level_o), 3);
        push(24, 4, 0);
        check("bp_fifth_accepted", int'(level_o), 4);
        wait_drain(300);
        check("bp_starts", n_starts - s0, 5);

        // Output stall
        out_ready_i = 1'b0;
        s0 = n_starts;
        push(16, 4, 0);
        push(9, 3, 0);
        t = 0;
        while (!out_valid_o && t < 100) begin
            tick();
            t++;
        end
        check("stall_valid", int'(out_valid_o), 1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid_o || out_op_o != 5'd16 || out_result_o != 5'd4 || out_err_o)
                stable = 1'b0;
        end
        check("stall_stable", int'(stable), 1);
        check("stall_one_start", n_starts - s0, 1);
        check("stall_level", int'(level_o), 1);
        out_ready_i = 1'b1;
        wait_drain(100);
        check("stall_starts", n_starts - s0, 2);

        // Timeout with a silent sqrt
        stub_respond = 1'b0;
        push(7, 0, 1);
        tick();
        check("to_start", int'(sq_start_o), 1);
        t = 0;
        while (!out_valid_o && t < 200) begin
            tick();
            t++;
        end
        check("to_latency", t, TIMEOUT + 1);
        check("to_err", int'(out_err_o), 1);
        check("to_result", int'(out_result_o), 0);
        tick(3);
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_o) seen = 1'b1;
            tick();
        end
        check("to_late_valid_ignored", int'(seen), 0);
        stub_respond = 1'b1;

        // Reset in the middle of WAIT
        stub_lat = 20;
        s0 = n_starts;
        push(16, 4, 0, 1'b0);
        push(9, 3, 0, 1'b0);
        push(25, 5, 0, 1'b0);
        tick(3);
        check("rst_level_before", int'(level_o), 2);
        check("rst_started", n_starts - s0, 1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midwait_rst");
        tick();
        rst_i = 1'b0;
        tick();
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid_o || sq_start_o) seen = 1'b1;
            tick();
        end
        check("rst_stale_valid_ignored", int'(seen), 0);
        check("rst_level_after", int'(level_o), 0);

        // Recovery after reset
        stub_lat = 3;
        push(25, 5, 0);
        wait_drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
